// File: rtl/fp_left_normalize.sv
// fp_left_normalize: two-stage elastic left normalizer with exponent-clamped shift
module fp_left_normalize #(
   parameter int FRAC_W = 26,
   parameter int EXP_W  = 8
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FRAC_W-1:0] in_fraction,
   input  logic [EXP_W-1:0]  in_exponent,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FRAC_W-1:0] out_fraction,
   output logic [EXP_W-1:0]  out_exponent,
   output logic [7:0]        out_shift,
   output logic              out_zero,
   output logic              out_denorm
);
   localparam int LZ_W = $clog2(FRAC_W + 1);
   localparam int W    = (LZ_W > EXP_W) ? LZ_W : EXP_W;
   logic              adv2;
   logic              in_fire;
   logic [LZ_W-1:0]   lzc;
   logic              s1_valid;
   logic [FRAC_W-1:0] s1_frac;
   logic [EXP_W-1:0]  s1_exp;
   logic [LZ_W-1:0]   s1_lzc;
   logic [W-1:0]      lzc_x;
   logic [W-1:0]      exp_x;
   logic              zero;
   logic              clamp;
   logic [LZ_W-1:0]   shift;
   logic [FRAC_W-1:0] frac_n;
   logic [EXP_W-1:0]  exp_n;
   assign adv2     = !out_valid || out_ready;
   assign in_ready = !s1_valid || adv2;
   assign in_fire  = in_valid && in_ready;
   // leading-zero count from the MSB; the highest set bit wins, all-zero gives FRAC_W
   always_comb begin
      lzc = LZ_W'(FRAC_W);
      for (int i = 0; i < FRAC_W; i++)
         if (in_fraction[i]) lzc = LZ_W'(FRAC_W - 1 - i);
   end
   // shift amount is limited by the exponent so the result never underflows below zero
   always_comb begin
      lzc_x  = W'(s1_lzc);
      exp_x  = W'(s1_exp);
      zero   = s1_lzc == LZ_W'(FRAC_W);
      clamp  = !zero && (lzc_x > exp_x);
      shift  = zero ? '0 : (clamp ? LZ_W'(exp_x) : s1_lzc);
      frac_n = s1_frac << shift;
      exp_n  = zero ? '0 : s1_exp - EXP_W'(shift);
   end
   // stage 1: capture operands and leading-zero count; empty when the item moves on
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         s1_valid <= 1'b0;
         s1_frac  <= '0;
         s1_exp   <= '0;
         s1_lzc   <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_frac  <= in_fraction;
         s1_exp   <= in_exponent;
         s1_lzc   <= lzc;
      end else if (adv2) begin
         s1_valid <= 1'b0;
      end
   end
   // stage 2: result registers load whenever downstream can take a new item
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         out_valid    <= 1'b0;
         out_fraction <= '0;
         out_exponent <= '0;
         out_shift    <= '0;
         out_zero     <= 1'b0;
         out_denorm   <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_fraction <= frac_n;
            out_exponent <= exp_n;
            out_shift    <= 8'(shift);
            out_zero     <= zero;
            out_denorm   <= clamp;
         end
      end
   end
endmodule

// File: tb/tb_fp_left_normalize.sv
// tb_fp_left_normalize: vector table, directed corners and randomized scoreboard for fp_left_normalize
module tb_fp_left_normalize;
   typedef struct packed {
      logic [25:0] f;
      logic [7:0]  e;
      logic [7:0]  s;
      logic        z;
      logic        d;
   } res_t;
   typedef struct {
      logic [25:0] f;
      logic [7:0]  e;
      res_t        x;
   } vec_t;
   logic        CLK = 0, nRST = 0, in_valid = 0, out_ready = 0;
   logic        in_ready, out_valid, out_zero, out_denorm;
   logic [25:0] in_fraction = '0, out_fraction;
   logic [7:0]  in_exponent = '0, out_exponent, out_shift;
   int          checks = 0, fails = 0;
   res_t        exp_q[$];
   res_t        held, pend;
   bit          held_valid = 0, use_pend = 0, fired = 0, log_on = 0;
   bit          ov_log[$];
   vec_t        tbl[8];
   always #5 CLK = ~CLK;
   fp_left_normalize dut (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
      .in_fraction(in_fraction), .in_exponent(in_exponent),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_fraction(out_fraction), .out_exponent(out_exponent),
      .out_shift(out_shift), .out_zero(out_zero), .out_denorm(out_denorm)
   );
   function automatic res_t model(logic [25:0] f, logic [7:0] e);
      res_t r;
      int   s = 0;
      r = '0;
      if (f == 0) begin
         r.z = 1'b1;
         return r;
      end
      while (!f[25] && e != 0) begin
         f = f << 1;
         e = e - 8'd1;
         s++;
      end
      r.f = f;
      r.e = e;
      r.s = 8'(s);
      r.d = !f[25];
      return r;
   endfunction
   function automatic vec_t mkv(logic [25:0] f, logic [7:0] e, logic [25:0] xf, logic [7:0] xe,
                                logic [7:0] xs, logic xz, logic xd);
      vec_t v;
      v.f = f; v.e = e;
      v.x.f = xf; v.x.e = xe; v.x.s = xs; v.x.z = xz; v.x.d = xd;
      return v;
   endfunction
   function automatic logic [25:0] rnd_frac();
      logic [25:0] v = 26'($urandom);
      return v >> $urandom_range(0, 26);
   endfunction
   function automatic logic [7:0] rnd_exp();
      return ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
   endfunction
   function automatic void check(bit ok, string name, logic [63:0] got, logic [63:0] want);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
      end
   endfunction
   function automatic res_t actual();
      return {out_fraction, out_exponent, out_shift, out_zero, out_denorm};
   endfunction
   task automatic cycle();
      res_t act, w;
      bit   want_r;
      @(negedge CLK);
      act = actual();
      if (log_on) ov_log.push_back(out_valid);
      want_r = (exp_q.size() < 2) || out_ready;
      check(in_ready == want_r, "in_ready", 64'(in_ready), 64'(want_r));
      if (held_valid) check(out_valid && act == held, "stall_hold", {out_valid, act}, {1'b1, held});
      if (out_valid) begin
         check(exp_q.size() != 0, "phantom_out", 64'(act), 64'(0));
         if (out_ready && exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check(act == w, "result", act, w);
         end
      end
      held_valid = out_valid && !out_ready;
      held = act;
      fired = in_valid && in_ready;
      if (fired) exp_q.push_back(use_pend ? pend : model(in_fraction, in_exponent));
      @(posedge CLK);
      #1;
   endtask
   task automatic drain(string nm, int budget);
      for (int k = 0; k < budget && exp_q.size() != 0; k++) cycle();
      check(exp_q.size() == 0, nm, 64'(exp_q.size()), 64'(0));
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int   sent;
      bit   pat[4];
      logic [25:0] bf[6];
      logic [7:0]  be[6];
      tbl[0] = mkv(26'h0000100, 8'd100, 26'h2000000, 8'd83, 8'd17, 1'b0, 1'b0);
      tbl[1] = mkv(26'h0000001, 8'd5,   26'h0000020, 8'd0,  8'd5,  1'b0, 1'b1);
      tbl[2] = mkv(26'h0000000, 8'd77,  26'h0000000, 8'd0,  8'd0,  1'b1, 1'b0);
      tbl[3] = mkv(26'h2000000, 8'd1,   26'h2000000, 8'd1,  8'd0,  1'b0, 1'b0);
      tbl[4] = mkv(26'h0001234, 8'd0,   26'h0001234, 8'd0,  8'd0,  1'b0, 1'b1);
      tbl[5] = mkv(26'h0000001, 8'd25,  26'h2000000, 8'd0,  8'd25, 1'b0, 1'b0);
      tbl[6] = mkv(26'h3FFFFFF, 8'd255, 26'h3FFFFFF, 8'd255, 8'd0, 1'b0, 1'b0);
      tbl[7] = mkv(26'h0800000, 8'd2,   26'h2000000, 8'd0,  8'd2,  1'b0, 1'b0);
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
      #12;
      check(!out_valid, "reset_out_valid", 64'(out_valid), 64'(0));
      check(in_ready, "reset_in_ready", 64'(in_ready), 64'(1));
      check(actual() == '0, "reset_data", 64'(actual()), 64'(0));
      @(posedge CLK);
      #1;
      nRST = 1;
      // table vectors, one at a time through an empty pipe
      out_ready = 1;
      use_pend = 1;
      foreach (tbl[i]) begin
         in_fraction = tbl[i].f;
         in_exponent = tbl[i].e;
         pend = tbl[i].x;
         in_valid = 1;
         cycle();
         check(fired, "tbl_accept", 64'(fired), 64'(1));
         in_valid = 0;
         drain("tbl_drain", 8);
      end
      use_pend = 0;
      // throughput: 20 back-to-back items, results in 20 consecutive cycles from cycle 2
      ov_log.delete();
      log_on = 1;
      for (int i = 0; i < 22; i++) begin
         in_valid = i < 20;
         in_fraction = rnd_frac();
         in_exponent = rnd_exp();
         cycle();
         if (i < 20) check(fired, "tput_accept", 64'(fired), 64'(1));
      end
      log_on = 0;
      in_valid = 0;
      for (int i = 0; i < 22; i++)
         check(ov_log[i] == (i >= 2), "tput_out_valid", 64'(ov_log[i]), 64'(i >= 2));
      drain("tput_drain", 4);
      // backpressure with out_ready following 1-0-0-1
      for (int i = 0; i < 6; i++) begin
         bf[i] = rnd_frac();
         be[i] = rnd_exp();
      end
      sent = 0;
      for (int c = 0; c < 80 && (sent < 6 || exp_q.size() != 0); c++) begin
         out_ready = pat[c % 4];
         in_valid = sent < 6;
         in_fraction = bf[sent < 6 ? sent : 0];
         in_exponent = be[sent < 6 ? sent : 0];
         cycle();
         if (fired) sent++;
      end
      in_valid = 0;
      check(sent == 6 && exp_q.size() == 0, "bp_complete", 64'(sent), 64'(6));
      // randomized soak with random valid/ready
      for (int c = 0; c < 400; c++) begin
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         in_fraction = rnd_frac();
         in_exponent = rnd_exp();
         cycle();
      end
      in_valid = 0;
      out_ready = 1;
      drain("soak_drain", 6);
      // async reset with two items in flight
      out_ready = 0;
      in_valid = 1;
      in_fraction = 26'h0000100;
      in_exponent = 8'd100;
      cycle();
      in_fraction = 26'h0000001;
      in_exponent = 8'd5;
      cycle();
      in_valid = 0;
      #2;
      nRST = 0;
      #1;
      check(!out_valid, "midreset_out_valid", 64'(out_valid), 64'(0));
      check(in_ready, "midreset_in_ready", 64'(in_ready), 64'(1));
      check(actual() == '0, "midreset_data", 64'(actual()), 64'(0));
      exp_q.delete();
      held_valid = 0;
      @(posedge CLK);
      #1;
      nRST = 1;
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check(!out_valid, "post_reset_idle", 64'(out_valid), 64'(0));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
